// File: rtl/gbe_tx_packetizer.sv
// gbe_tx_packetizer: frames a stream of payload words into fixed-length packets
// for a 10GbE core TX port. Each packet carries PKT_WORDS payload words, the
// last one flagged with tx_eof, and is followed by GAP_CYCLES forced idle cycles.
// A new packet only starts when the core's TX buffer is not almost full. Once
// started, a packet always runs to completion.
// Optional feature: define GBE_TX_HEADER_EN to prepend one header word per packet.
module gbe_tx_packetizer #(
  parameter int DIN_WIDTH  = 64,
  parameter int PKT_WORDS  = 128,
  parameter int GAP_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 tx_afull,
  output logic [DIN_WIDTH-1:0] tx_data,
  output logic                 tx_valid,
  output logic                 tx_eof,
  output logic [31:0]          pkt_count,
  output logic                 busy
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_WORDS - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t      state, state_nxt;
  logic [15:0] word_cnt;
  logic [7:0]  gap_cnt;
  logic        accept;
  logic        last_word;
  logic        gap_done;

  assign din_ready = (state == DATA);
  assign busy      = (state != IDLE);
  assign accept    = din_valid && (state == DATA);
  assign last_word = accept && (word_cnt == LAST_IDX);
  assign gap_done  = (gap_cnt == GAP_LAST);

`ifdef GBE_TX_HEADER_EN
  localparam logic [15:0] PKT_W16 = 16'(PKT_WORDS);
  logic [63:0] hdr_word;
  // Header carries a magic tag, the packet length and the index of this packet.
  assign hdr_word = {16'hCA5E, PKT_W16, pkt_count};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; tx_afull only gates the start of a packet
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (din_valid && !tx_afull) begin
`ifdef GBE_TX_HEADER_EN
          state_nxt = HDR;
`else
          state_nxt = DATA;
`endif
        end
      end
      HDR:     state_nxt = DATA;
      DATA:    if (last_word) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word index within the packet; held at zero outside DATA so entry starts clean
  always_ff @(posedge clk) begin
    if (rst || state != DATA) word_cnt <= '0;
    else if (accept)          word_cnt <= word_cnt + 16'd1;
  end

  // Inter-packet gap length counter
  always_ff @(posedge clk) begin
    if (rst || state != GAP) gap_cnt <= '0;
    else                     gap_cnt <= gap_cnt + 8'd1;
  end

  // Registered TX outputs and completed-packet counter (wraps naturally)
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      tx_eof    <= 1'b0;
      pkt_count <= '0;
    end else begin
      tx_valid <= 1'b0;
      tx_eof   <= 1'b0;
      case (state)
`ifdef GBE_TX_HEADER_EN
        HDR: begin
          tx_data  <= DIN_WIDTH'(hdr_word);
          tx_valid <= 1'b1;
        end
`endif
        DATA: begin
          if (accept) begin
            tx_data  <= din;
            tx_valid <= 1'b1;
            tx_eof   <= last_word;
          end
          if (last_word) pkt_count <= pkt_count + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// Directed bench for gbe_tx_packetizer with PKT_WORDS=4, GAP_CYCLES=2.
// Header expectations follow GBE_TX_HEADER_EN when it is defined.
module tb_gbe_tx_packetizer;

  logic        clk;
  logic        rst;
  logic [63:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        tx_afull;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_eof;
  logic [31:0] pkt_count;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] nxt;

  gbe_tx_packetizer #(.DIN_WIDTH(64), .PKT_WORDS(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .tx_afull(tx_afull), .tx_data(tx_data), .tx_valid(tx_valid), .tx_eof(tx_eof),
    .pkt_count(pkt_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check din_ready mid-cycle, then check the outputs
  // registered by the edge. nxt advances only on cycles expected to transfer.
  task automatic step(input logic v, input logic rdy, input logic tv, input logic eof,
                      input logic [63:0] d, input string tag);
    din_valid = v;
    din       = v ? nxt : 64'hDEAD_BEEF_0000_0000;
    @(negedge clk);
    chk({tag, "/rdy"}, din_ready, rdy);
    @(posedge clk); #1;
    if (v && rdy) nxt = nxt + 64'd1;
    chk({tag, "/tv"}, tx_valid, tv);
    chk({tag, "/eof"}, tx_eof, eof);
    if (tv) chk({tag, "/data"}, tx_data, d);
  endtask

  // Full packet from IDLE with din_valid held high, through the gap back to IDLE.
  task automatic packet(input logic [31:0] cnt, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, {tag, "/idle"});
`ifdef GBE_TX_HEADER_EN
    step(1'b1, 1'b0, 1'b1, 1'b0, {16'hCA5E, 16'd4, cnt}, {tag, "/hdr"});
`else
    chk({tag, "/cnt"}, pkt_count, cnt);
`endif
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b1, (i == 3), nxt, $sformatf("%s/w%0d", tag, i));
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, {tag, "/gap0"});
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, {tag, "/gap1"});
    chk({tag, "/busy_end"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; tx_afull = 1'b0; nxt = 64'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst/tv", tx_valid, 1'b0);
    chk("rst/eof", tx_eof, 1'b0);
    chk("rst/data", tx_data, 64'd0);
    chk("rst/rdy", din_ready, 1'b0);
    chk("rst/busy", busy, 1'b0);
    chk("rst/cnt", pkt_count, 32'd0);

    // Two back-to-back packets, din = 1..8
    packet(32'd0, "p1");
    chk("p1/pkt_count", pkt_count, 32'd1);
    packet(32'd1, "p2");
    chk("p2/pkt_count", pkt_count, 32'd2);

    // Almost-full holds the block in IDLE, release starts a packet
    tx_afull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, "afull");
      chk("afull/busy", busy, 1'b0);
    end
    tx_afull = 1'b0;
    packet(32'd2, "p3");
    chk("p3/pkt_count", pkt_count, 32'd3);

    // din_valid toggling inside DATA: output mirrors one cycle later
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, "tog/idle");
`ifdef GBE_TX_HEADER_EN
    step(1'b1, 1'b0, 1'b1, 1'b0, {16'hCA5E, 16'd4, 32'd3}, "tog/hdr");
`endif
    for (int i = 0; i < 7; i++) begin
      step((i % 2 == 0), 1'b1, (i % 2 == 0), (i == 6), nxt, $sformatf("tog/c%0d", i));
      if (i == 0) chk("tog/busy", busy, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, "tog/gap0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, "tog/gap1");
    chk("tog/pkt_count", pkt_count, 32'd4);

    // Reset after two words abandons the packet
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, "rmid/idle");
`ifdef GBE_TX_HEADER_EN
    step(1'b1, 1'b0, 1'b1, 1'b0, {16'hCA5E, 16'd4, 32'd4}, "rmid/hdr");
`endif
    step(1'b1, 1'b1, 1'b1, 1'b0, nxt, "rmid/w0");
    step(1'b1, 1'b1, 1'b1, 1'b0, nxt, "rmid/w1");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmid/tv", tx_valid, 1'b0);
    chk("rmid/eof", tx_eof, 1'b0);
    chk("rmid/data", tx_data, 64'd0);
    chk("rmid/rdy", din_ready, 1'b0);
    chk("rmid/busy", busy, 1'b0);
    chk("rmid/cnt", pkt_count, 32'd0);
    packet(32'd0, "p4");
    chk("p4/pkt_count", pkt_count, 32'd1);

    // Packet counter wrap
    force dut.pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count;
    chk("wrap/preset", pkt_count, 32'hFFFF_FFFF);
    packet(32'hFFFF_FFFF, "p5");
    chk("wrap/pkt_count", pkt_count, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
